// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared state/requester encodings and default widths for the register-file write controller
package regfile_ctrl_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

endpackage

// File: rtl/regfile_wr_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; on contention the requester that did not win last time is granted
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ack,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       next_last
);

    always_comb begin
        gnt[REQ_ALU] = req[REQ_ALU] && (!req[REQ_MEM] || last == REQ_MEM);
        gnt[REQ_MEM] = req[REQ_MEM] && (!req[REQ_ALU] || last == REQ_ALU);
        next_last    = (ack && |gnt) ? (gnt[REQ_MEM] ? REQ_MEM : REQ_ALU) : last;
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: clears every register after reset, then shares the single write port between ALU and load writeback
module regfile_wr_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int NREGS          = DEF_NREGS,
    parameter int AW             = DEF_AW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic            busy
);

    localparam state_t RST_STATE = state_t'(CLEAR_ON_RESET ? ST_CLEAR : ST_RUN);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt;
    logic            last, next_last;
    logic [1:0]      gnt;
    logic            run, accept;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    rr_arb2 u_arb (
        .req      ({mem_valid, alu_valid}),
        .ack      (run),
        .last     (last),
        .gnt      (gnt),
        .next_last(next_last)
    );

    always_comb begin
        run       = state == ST_RUN;
        busy      = !run;
        alu_ready = run && gnt[REQ_ALU];
        mem_ready = run && gnt[REQ_MEM];
        accept    = run && |gnt;
        sel_rd    = gnt[REQ_MEM] ? mem_rd : alu_rd;
        sel_data  = gnt[REQ_MEM] ? mem_data : alu_data;
        state_nxt = (!run && cnt == AW'(NREGS - 1)) ? ST_RUN : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
            last  <= REQ_MEM;
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            state <= state_nxt;
            last  <= next_last;
            if (!run) begin
                rf_we <= 1'b1;
                rf_a3 <= cnt;
                rf_wd <= '0;
                cnt   <= cnt + AW'(1);
            end else begin
                // x0 writes are consumed but never reach the register file
                rf_we <= accept && sel_rd != '0;
                if (accept) begin
                    rf_a3 <= sel_rd;
                    rf_wd <= sel_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl: directed checks of the clear walk, arbitration, x0 drop, stall during clear and mid-walk reset
module tb_regfile_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rf_we, busy;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    int          checks = 0;
    int          errors = 0;

    regfile_wr_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .alu_valid(alu_valid),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .rf_we    (rf_we),
        .rf_a3    (rf_a3),
        .rf_wd    (rf_wd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic walk(input int first);
        for (int i = first; i < 32; i++) begin
            tick();
            chk("walk_we", 32'(rf_we), 32'd1);
            chk("walk_a3", 32'(rf_a3), 32'(i));
            chk("walk_wd", rf_wd, 32'd0);
            chk("walk_busy", 32'(busy), 32'(i < 31));
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
        repeat (3) tick();
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_a3", 32'(rf_a3), 32'd0);
        chk("rst_wd", rf_wd, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        walk(0);
        tick();
        chk("run_idle_we", 32'(rf_we), 32'd0);
        chk("run_busy", 32'(busy), 32'd0);

        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_alu_rdy", 32'(alu_ready), 32'(k % 2 == 0));
            chk("cont_mem_rdy", 32'(mem_ready), 32'(k % 2 == 1));
            tick();
            chk("cont_we", 32'(rf_we), 32'd1);
            chk("cont_a3", 32'(rf_a3), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_wd", rf_wd, (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;

        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("alu_rdy", 32'(alu_ready), 32'd1);
        chk("alu_mem_rdy", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        chk("alu_we", 32'(rf_we), 32'd1);
        chk("alu_a3", 32'(rf_a3), 32'd5);
        chk("alu_wd", rf_wd, 32'hDEADBEEF);
        tick();
        chk("alu_we_off", 32'(rf_we), 32'd0);
        chk("alu_a3_hold", 32'(rf_a3), 32'd5);
        chk("alu_wd_hold", rf_wd, 32'hDEADBEEF);

        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        #1;
        chk("x0_rdy", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        chk("x0_we", 32'(rf_we), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        for (int i = 2; i < 32; i++) begin
            #1;
            chk("stall_rdy", 32'(alu_ready), 32'd0);
            tick();
        end
        chk("stall_busy", 32'(busy), 32'd0);
        chk("stall_run_rdy", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("stall_we", 32'(rf_we), 32'd1);
        chk("stall_a3", 32'(rf_a3), 32'd7);
        chk("stall_wd", rf_wd, 32'h77);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_a3", 32'(rf_a3), 32'd9);
        rst = 1'b1;
        #1;
        chk("async_we", 32'(rf_we), 32'd0);
        chk("async_a3", 32'(rf_a3), 32'd0);
        chk("async_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        walk(0);
        tick();
        chk("mid_end_we", 32'(rf_we), 32'd0);
        chk("mid_end_busy", 32'(busy), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
        #1;
        chk("post_rst_alu_first", 32'(alu_ready), 32'd1);
        chk("post_rst_mem_wait", 32'(mem_ready), 32'd0);
        tick();
        chk("post_rst_a3", 32'(rf_a3), 32'd3);
        alu_valid = 1'b0; mem_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
